// File: rtl/ascon_perm_engine_pkg.sv
// Shared types and helpers for the ASCON permutation engine: state layout, FSM encoding,
// round constant and 64-bit rotate.
package ascon_perm_engine_pkg;

    localparam int ROUNDS_MAX = 12;

    // Element 0 is the most significant word, so x0 sits in bits [319:256].
    typedef logic [0:4][63:0] state_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } fsm_t;

    function automatic logic [7:0] ascon_rc(input logic [3:0] k);
        return {4'hF - k, k};
    endfunction

    function automatic logic [63:0] ror64(input logic [63:0] x, input int unsigned r);
        return (x >> r) | (x << (64 - r));
    endfunction

endpackage

// File: rtl/ascon_perm_engine_round.sv
// One full ASCON round (constant addition, 5-bit S-box layer, linear diffusion); purely
// combinational, zero latency, no flow control.
module ascon_round
    import ascon_perm_engine_pkg::*;
(
    input  state_t      state,
    input  logic [3:0]  k,
    output state_t      state_nxt
);

    state_t a;
    state_t b;

    always_comb begin
        a = state;
        a[2][7:0] = state[2][7:0] ^ ascon_rc(k);

        // Bitsliced S-box: input mixing, chi-like core, output mixing.
        a[0] = a[0] ^ a[4];
        a[4] = a[4] ^ a[3];
        a[2] = a[2] ^ a[1];

        b = a;
        b[0] = a[0] ^ (~a[1] & a[2]);
        b[1] = a[1] ^ (~a[2] & a[3]);
        b[2] = a[2] ^ (~a[3] & a[4]);
        b[3] = a[3] ^ (~a[4] & a[0]);
        b[4] = a[4] ^ (~a[0] & a[1]);

        b[1] = b[1] ^ b[0];
        b[0] = b[0] ^ b[4];
        b[3] = b[3] ^ b[2];
        b[2] = ~b[2];

        state_nxt[0] = b[0] ^ ror64(b[0], 19) ^ ror64(b[0], 28);
        state_nxt[1] = b[1] ^ ror64(b[1], 61) ^ ror64(b[1], 39);
        state_nxt[2] = b[2] ^ ror64(b[2],  1) ^ ror64(b[2],  6);
        state_nxt[3] = b[3] ^ ror64(b[3], 10) ^ ror64(b[3], 17);
        state_nxt[4] = b[4] ^ ror64(b[4],  7) ^ ror64(b[4], 41);
    end

endmodule

// File: rtl/ascon_perm_engine.sv
// Self-sequencing ASCON permutation, UNROLL rounds per edge; result after N/UNROLL edges.
// Accepts a request only while ready_o is high; starts during a run are dropped, not queued.
module ascon_perm_engine
    import ascon_perm_engine_pkg::*;
#(
    parameter int UNROLL   = 1,
    parameter int ROUNDS_A = 12,
    parameter int ROUNDS_B = 6
) (
    input  logic          clock_i,
    input  logic          resetb_i,
    input  logic          start_i,
    input  logic          rounds_sel_i,
    input  logic [319:0]  state_i,
    output logic          ready_o,
    output logic          busy_o,
    output logic          done_o,
    output logic [319:0]  state_o
);

    if (UNROLL < 1 || ROUNDS_A < 1 || ROUNDS_A > ROUNDS_MAX || ROUNDS_B < 1 ||
        ROUNDS_B > ROUNDS_MAX || (ROUNDS_A % UNROLL) != 0 || (ROUNDS_B % UNROLL) != 0)
    begin : g_cfg_check
        $error("ascon_perm_engine: round counts must be 1..12 and multiples of UNROLL");
    end

    localparam logic [3:0] UNR  = 4'(UNROLL);
    localparam logic [3:0] RA   = 4'(ROUNDS_A);
    localparam logic [3:0] RB   = 4'(ROUNDS_B);
    localparam logic [3:0] RMAX = 4'(ROUNDS_MAX);

    fsm_t        fsm_q, fsm_d;
    logic [3:0]  cnt_q, cnt_d, cnt_step;
    logic [3:0]  n_q, n_d, n_sel, n_cur, j_base, k_base;
    logic        done_q, done_d, load;
    state_t      state_q;

    logic [UNROLL:0][319:0] chain;

    assign n_sel    = rounds_sel_i ? RB : RA;
    assign cnt_step = cnt_q + UNR;

    // In IDLE the chain works on the incoming request so the first rounds land on the accept edge.
    assign chain[0] = (fsm_q == IDLE) ? state_i : state_q;
    assign n_cur    = (fsm_q == IDLE) ? n_sel : n_q;
    assign j_base   = (fsm_q == IDLE) ? 4'd0 : cnt_q;
    assign k_base   = RMAX - n_cur + j_base;

    for (genvar g = 0; g < UNROLL; g++) begin : g_round
        ascon_round u_round (
            .state     (chain[g]),
            .k         (k_base + 4'(g)),
            .state_nxt (chain[g+1])
        );
    end

    always_comb begin
        fsm_d  = fsm_q;
        cnt_d  = cnt_q;
        n_d    = n_q;
        done_d = 1'b0;
        load   = 1'b0;
        case (fsm_q)
            IDLE: begin
                if (start_i) begin
                    load  = 1'b1;
                    n_d   = n_sel;
                    cnt_d = UNR;
                    if (n_sel == UNR) begin
                        done_d = 1'b1;
                    end else begin
                        fsm_d = RUN;
                    end
                end
            end
            RUN: begin
                load  = 1'b1;
                cnt_d = cnt_step;
                if (cnt_step == n_q) begin
                    done_d = 1'b1;
                    fsm_d  = IDLE;
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (!resetb_i) begin
            fsm_q   <= IDLE;
            cnt_q   <= 4'd0;
            n_q     <= 4'd0;
            done_q  <= 1'b0;
            state_q <= '0;
        end else begin
            fsm_q  <= fsm_d;
            cnt_q  <= cnt_d;
            n_q    <= n_d;
            done_q <= done_d;
            if (load) begin
                state_q <= chain[UNROLL];
            end
        end
    end

    assign ready_o = (fsm_q == IDLE);
    assign busy_o  = (fsm_q == RUN);
    assign done_o  = done_q;
    assign state_o = state_q;

endmodule

// File: tb/tb_ascon_perm_engine.sv
// Scoreboard bench: drivers push expected results from an LUT-based reference permutation,
// a per-instance monitor pops and compares on every done_o pulse.
module tb_ascon_perm_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rb1, start1, sel1, ready1, busy1, done1;
    logic [319:0] st1, out1;
    logic         rb2, start2, sel2, ready2, busy2, done2;
    logic [319:0] st2, out2;

    ascon_perm_engine #(.UNROLL(1), .ROUNDS_A(12), .ROUNDS_B(6)) u1 (
        .clock_i(clk), .resetb_i(rb1), .start_i(start1), .rounds_sel_i(sel1), .state_i(st1),
        .ready_o(ready1), .busy_o(busy1), .done_o(done1), .state_o(out1)
    );

    ascon_perm_engine #(.UNROLL(2), .ROUNDS_A(12), .ROUNDS_B(6)) u2 (
        .clock_i(clk), .resetb_i(rb2), .start_i(start2), .rounds_sel_i(sel2), .state_i(st2),
        .ready_o(ready2), .busy_o(busy2), .done_o(done2), .state_o(out2)
    );

    localparam logic [4:0] SBOX [32] = '{
        5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
        5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
        5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
        5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
    };

    typedef struct {
        logic [319:0] st;
        int           cyc;
        int           k;
    } exp_t;

    exp_t q1[$];
    exp_t q2[$];
    exp_t m1, m2;

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int bc1 = 0;
    int bc2 = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] rot(input logic [63:0] v, input int r);
        logic [63:0] res;
        for (int i = 0; i < 64; i++) res[i] = v[(i + r) % 64];
        return res;
    endfunction

    function automatic logic [319:0] ref_perm(input logic [319:0] s, input int n);
        logic [63:0] x [5];
        logic [63:0] y [5];
        logic [4:0]  o;
        logic [7:0]  c;
        for (int i = 0; i < 5; i++) x[i] = s[319 - 64*i -: 64];
        for (int j = 0; j < n; j++) begin
            int k;
            k = 12 - n + j;
            c = {4'(15 - k), 4'(k)};
            x[2][7:0] = x[2][7:0] ^ c;
            for (int b = 0; b < 64; b++) begin
                o = SBOX[{x[0][b], x[1][b], x[2][b], x[3][b], x[4][b]}];
                y[0][b] = o[4];
                y[1][b] = o[3];
                y[2][b] = o[2];
                y[3][b] = o[1];
                y[4][b] = o[0];
            end
            x[0] = y[0] ^ rot(y[0], 19) ^ rot(y[0], 28);
            x[1] = y[1] ^ rot(y[1], 61) ^ rot(y[1], 39);
            x[2] = y[2] ^ rot(y[2],  1) ^ rot(y[2],  6);
            x[3] = y[3] ^ rot(y[3], 10) ^ rot(y[3], 17);
            x[4] = y[4] ^ rot(y[4],  7) ^ rot(y[4], 41);
        end
        return {x[0], x[1], x[2], x[3], x[4]};
    endfunction

    task automatic check_vec(input string name, input logic [319:0] act, input logic [319:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitors: one per instance, decoupled from the stimulus process.
    always @(negedge clk) begin
        if (busy1) bc1++;
        if (done1) begin
            if (q1.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL u1_spurious_done: done_o high at cycle %0d, expected no pending result", cyc);
            end else begin
                m1 = q1.pop_front();
                check_vec("u1_result", out1, m1.st);
                check_int("u1_done_cycle", cyc, m1.cyc);
                check_int("u1_busy_cycles", bc1, m1.k - 1);
            end
            bc1 = 0;
        end
    end

    always @(negedge clk) begin
        if (busy2) bc2++;
        if (done2) begin
            if (q2.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL u2_spurious_done: done_o high at cycle %0d, expected no pending result", cyc);
            end else begin
                m2 = q2.pop_front();
                check_vec("u2_result", out2, m2.st);
                check_int("u2_done_cycle", cyc, m2.cyc);
                check_int("u2_busy_cycles", bc2, m2.k - 1);
            end
            bc2 = 0;
        end
    end

    task automatic issue1(input logic [319:0] s, input logic sel);
        exp_t e;
        int   n;
        n     = sel ? 6 : 12;
        e.st  = ref_perm(s, n);
        e.k   = n;
        e.cyc = cyc + n;
        q1.push_back(e);
        start1 = 1'b1;
        sel1   = sel;
        st1    = s;
        @(negedge clk);
        start1 = 1'b0;
        sel1   = 1'($urandom);
        st1    = {10{$urandom}};
    endtask

    task automatic issue2(input logic [319:0] s, input logic sel);
        exp_t e;
        int   n;
        n     = sel ? 6 : 12;
        e.st  = ref_perm(s, n);
        e.k   = n / 2;
        e.cyc = cyc + n / 2;
        q2.push_back(e);
        start2 = 1'b1;
        sel2   = sel;
        st2    = s;
        @(negedge clk);
        start2 = 1'b0;
        sel2   = 1'($urandom);
        st2    = {10{$urandom}};
    endtask

    task automatic wait_done1(input string name, input int budget);
        int i;
        i = 0;
        while (!done1 && i < budget) begin
            @(negedge clk);
            i++;
        end
        if (!done1) begin
            checks++;
            errors++;
            $display("FAIL %s: no done_o within %0d cycles, expected a done pulse", name, budget);
        end
    endtask

    task automatic wait_done2(input string name, input int budget);
        int i;
        i = 0;
        while (!done2 && i < budget) begin
            @(negedge clk);
            i++;
        end
        if (!done2) begin
            checks++;
            errors++;
            $display("FAIL %s: no done_o within %0d cycles, expected a done pulse", name, budget);
        end
    endtask

    logic [319:0] v_init, v_a, v_zero, v_ones;

    initial begin
        #50000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        v_init = {64'h80400C0600000000, 128'h000102030405060708090A0B0C0D0E0F,
                  128'h00112233445566778899AABBCCDDEEFF};
        v_a    = 320'h0123456789ABCDEF_FEDCBA9876543210_0F1E2D3C4B5A6978_8796A5B4C3D2E1F0_DEADBEEFCAFEF00D;
        v_zero = '0;
        v_ones = '1;

        rb1 = 1'b0; start1 = 1'b0; sel1 = 1'b0; st1 = v_a;
        rb2 = 1'b0; start2 = 1'b0; sel2 = 1'b0; st2 = v_a;
        repeat (2) @(negedge clk);
        check_int("u1_reset_ready", int'(ready1), 1);
        check_int("u1_reset_busy",  int'(busy1),  0);
        check_int("u1_reset_done",  int'(done1),  0);
        check_vec("u1_reset_state", out1, v_zero);
        check_int("u2_reset_ready", int'(ready2), 1);
        check_int("u2_reset_busy",  int'(busy2),  0);
        check_int("u2_reset_done",  int'(done2),  0);
        check_vec("u2_reset_state", out2, v_zero);
        rb1 = 1'b1;
        rb2 = 1'b1;
        @(negedge clk);

        // UNROLL=1: p12 init, then back-to-back p6 and p12 started in the done cycle.
        issue1(v_init, 1'b0);
        wait_done1("u1_p12_init", 20);
        issue1(v_a, 1'b1);
        wait_done1("u1_b2b_p6", 20);
        issue1(v_zero, 1'b0);
        wait_done1("u1_b2b_p12_zero", 20);
        repeat (3) @(negedge clk);

        // A start during a run must not disturb the result or add a done pulse.
        issue1(v_init, 1'b0);
        repeat (3) @(negedge clk);
        start1 = 1'b1; sel1 = 1'b1; st1 = v_ones;
        @(negedge clk);
        start1 = 1'b0;
        wait_done1("u1_start_while_busy", 20);
        repeat (15) @(negedge clk);

        // Reset mid-run: abort, no done, state cleared.
        issue1(v_a, 1'b0);
        repeat (2) @(negedge clk);
        rb1 = 1'b0;
        q1.delete();
        @(negedge clk);
        check_vec("u1_midrun_reset_state", out1, v_zero);
        check_int("u1_midrun_reset_ready", int'(ready1), 1);
        check_int("u1_midrun_reset_busy",  int'(busy1),  0);
        check_int("u1_midrun_reset_done",  int'(done1),  0);
        bc1 = 0;
        rb1 = 1'b1;
        repeat (16) @(negedge clk);

        // UNROLL=2: p6 init vector, then back-to-back p12 and p6.
        issue2(v_init, 1'b1);
        wait_done2("u2_p6_init", 10);
        issue2(v_a, 1'b0);
        wait_done2("u2_b2b_p12", 10);
        issue2(v_ones, 1'b1);
        wait_done2("u2_b2b_p6_ones", 10);
        repeat (8) @(negedge clk);

        check_int("u1_queue_drained", q1.size(), 0);
        check_int("u2_queue_drained", q2.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
